// File: rtl/seg7_pkg.sv
// Shared types, constants and the hex font for the 7-segment scan driver.
// Segment patterns are active-low, ordered {a,b,c,d,e,f,g}.
package seg7_pkg;

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } seg7_state_e;

    localparam logic [7:0] SEG_OFF = 8'hFF;

    function automatic logic [6:0] hex_to_seg7(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'b0000001;
            4'h1:    s = 7'b1001111;
            4'h2:    s = 7'b0010010;
            4'h3:    s = 7'b0000110;
            4'h4:    s = 7'b1001100;
            4'h5:    s = 7'b0100100;
            4'h6:    s = 7'b0100000;
            4'h7:    s = 7'b0001111;
            4'h8:    s = 7'b0000000;
            4'h9:    s = 7'b0000100;
            4'hA:    s = 7'b0001000;
            4'hB:    s = 7'b1100000;
            4'hC:    s = 7'b0110001;
            4'hD:    s = 7'b1000010;
            4'hE:    s = 7'b0110000;
            default: s = 7'b0111000;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus between the value source (master) and the scan driver (slave):
// display data/controls in, multiplexed display pins and frame pulse out.
interface seg7_scan_driver_if #(
    parameter int NUM_DIGITS = 8
);
    logic [4*NUM_DIGITS-1:0] data_in;
    logic [NUM_DIGITS-1:0]   dp_in;
    logic                    load;
    logic                    enable_n;
    logic [NUM_DIGITS-1:0]   sel;
    logic [7:0]              seg;
    logic                    frame_done;

    modport master (
        output data_in, dp_in, load, enable_n,
        input  sel, seg, frame_done
    );

    modport slave (
        input  data_in, dp_in, load, enable_n,
        output sel, seg, frame_done
    );
endinterface

// File: rtl/seg7_hex_decoder.sv
// Combinational nibble + decimal point to active-low {a..g,dp} segment byte.
module seg7_hex_decoder
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg
);

    assign seg = {hex_to_seg7(nibble), ~dp};

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed hex display driver: BLANK/SHOW scan per digit, frame-coherent
// shadow data, optional leading-zero blanking, registered active-low outputs.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 2048,
    parameter int BLANK_CYCLES = 16,
    parameter int LZ_BLANK     = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    seg7_scan_driver_if.slave    bus
);

    localparam int DATA_W  = 4 * NUM_DIGITS;
    localparam int CNT_MAX = (SCAN_DIV > BLANK_CYCLES) ? SCAN_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(CNT_MAX);
    localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] SHOW_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_CYCLES > 0) ? BLANK_CYCLES - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);
    localparam seg7_state_e      ST_RESET   = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;

    seg7_state_e             state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    frame_done_q, frame_done_d;

    logic [DATA_W-1:0]       pend_data_q, pend_data_d;
    logic [NUM_DIGITS-1:0]   pend_dp_q, pend_dp_d;
    logic                    pend_vld_q, pend_vld_d;
    logic [DATA_W-1:0]       shadow_data_q, shadow_data_d;
    logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;

    logic [NUM_DIGITS-1:0]   sel_q, sel_d;
    logic [7:0]              seg_q, seg_d;

    logic [NUM_DIGITS-1:0]   lz_mask;
    logic                    lz_run;
    logic [3:0]              cur_nib;
    logic                    cur_dp;
    logic                    cur_lz;
    logic [7:0]              dec_seg;

    // Scan FSM: the phase counter restarts on every state change; frame_done_d
    // marks the last SHOW cycle of the last digit, i.e. the frame boundary.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q + CNT_W'(1);
        idx_d        = idx_q;
        frame_done_d = 1'b0;
        case (state_q)
            ST_BLANK: begin
                if (cnt_q == BLANK_LAST) begin
                    state_d = ST_SHOW;
                    cnt_d   = '0;
                end
            end
            ST_SHOW: begin
                if (cnt_q == SHOW_LAST) begin
                    cnt_d   = '0;
                    state_d = (BLANK_CYCLES == 0) ? ST_SHOW : ST_BLANK;
                    if (idx_q == IDX_LAST) begin
                        idx_d        = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_RESET;
                cnt_d   = '0;
            end
        endcase
    end

    // Loads park in the pending copy; the shadow only moves at the frame
    // boundary so a frame never mixes old and new digits.
    always_comb begin
        pend_data_d   = pend_data_q;
        pend_dp_d     = pend_dp_q;
        pend_vld_d    = pend_vld_q;
        shadow_data_d = shadow_data_q;
        shadow_dp_d   = shadow_dp_q;
        if (bus.load) begin
            pend_data_d = bus.data_in;
            pend_dp_d   = bus.dp_in;
            pend_vld_d  = 1'b1;
        end
        if (frame_done_d) begin
            pend_vld_d = 1'b0;
            if (bus.load) begin
                shadow_data_d = bus.data_in;
                shadow_dp_d   = bus.dp_in;
            end else if (pend_vld_q) begin
                shadow_data_d = pend_data_q;
                shadow_dp_d   = pend_dp_q;
            end
        end
    end

    // A digit is a leading zero while every digit up to it is 0 with no dp;
    // the last digit always stays lit.
    always_comb begin
        lz_mask = '0;
        lz_run  = 1'b1;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            lz_run = lz_run & (shadow_data_q[DATA_W-1-4*i -: 4] == 4'h0) & ~shadow_dp_q[i];
            lz_mask[i] = (LZ_BLANK != 0) && lz_run && (i < NUM_DIGITS - 1);
        end
    end

    always_comb begin
        cur_nib = 4'h0;
        cur_dp  = 1'b0;
        cur_lz  = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = shadow_data_q[DATA_W-1-4*i -: 4];
                cur_dp  = shadow_dp_q[i];
                cur_lz  = lz_mask[i];
            end
        end
    end

    seg7_hex_decoder u_dec (
        .nibble (cur_nib),
        .dp     (cur_dp),
        .seg    (dec_seg)
    );

    always_comb begin
        sel_d = '1;
        seg_d = SEG_OFF;
        if (state_q == ST_SHOW && !bus.enable_n && !cur_lz) begin
            sel_d = ~(NUM_DIGITS'(1) << idx_q);
            seg_d = dec_seg;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_RESET;
            cnt_q         <= '0;
            idx_q         <= '0;
            frame_done_q  <= 1'b0;
            pend_data_q   <= '0;
            pend_dp_q     <= '0;
            pend_vld_q    <= 1'b0;
            shadow_data_q <= '0;
            shadow_dp_q   <= '0;
            sel_q         <= '1;
            seg_q         <= SEG_OFF;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            idx_q         <= idx_d;
            frame_done_q  <= frame_done_d;
            pend_data_q   <= pend_data_d;
            pend_dp_q     <= pend_dp_d;
            pend_vld_q    <= pend_vld_d;
            shadow_data_q <= shadow_data_d;
            shadow_dp_q   <= shadow_dp_d;
            sel_q         <= sel_d;
            seg_q         <= seg_d;
        end
    end

    assign bus.sel        = sel_q;
    assign bus.seg        = seg_q;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: three instances (blank gap, leading-zero
// blanking, no gap) share stimulus; one monitored instance is captured per frame.
module tb_seg7_scan_driver;

    logic        clk;
    logic        rst;
    logic [15:0] data_in;
    logic [3:0]  dp_in;
    logic        load;
    logic        enable_n;

    int checks;
    int failures;
    int mon;

    logic [3:0] mon_sel;
    logic [7:0] mon_seg;
    logic       mon_fd;

    logic [3:0] cap_sel [1:24];
    logic [7:0] cap_seg [1:24];
    logic       cap_fd  [1:24];

    seg7_scan_driver_if #(.NUM_DIGITS(4)) if_a  ();
    seg7_scan_driver_if #(.NUM_DIGITS(4)) if_lz ();
    seg7_scan_driver_if #(.NUM_DIGITS(4)) if_nb ();

    assign if_a.data_in   = data_in;
    assign if_a.dp_in     = dp_in;
    assign if_a.load      = load;
    assign if_a.enable_n  = enable_n;
    assign if_lz.data_in  = data_in;
    assign if_lz.dp_in    = dp_in;
    assign if_lz.load     = load;
    assign if_lz.enable_n = enable_n;
    assign if_nb.data_in  = data_in;
    assign if_nb.dp_in    = dp_in;
    assign if_nb.load     = load;
    assign if_nb.enable_n = enable_n;

    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(2), .LZ_BLANK(0)) dut_a (
        .clk (clk), .rst (rst), .bus (if_a)
    );
    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(2), .LZ_BLANK(1)) dut_lz (
        .clk (clk), .rst (rst), .bus (if_lz)
    );
    seg7_scan_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .BLANK_CYCLES(0), .LZ_BLANK(0)) dut_nb (
        .clk (clk), .rst (rst), .bus (if_nb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        mon_sel = if_nb.sel;
        mon_seg = if_nb.seg;
        mon_fd  = if_nb.frame_done;
        if (mon == 0) begin
            mon_sel = if_a.sel;
            mon_seg = if_a.seg;
            mon_fd  = if_a.frame_done;
        end else if (mon == 1) begin
            mon_sel = if_lz.sel;
            mon_seg = if_lz.seg;
            mon_fd  = if_lz.frame_done;
        end
    end

    // Expected output in cycle k of a frame (k=0 is the frame_done cycle):
    // each digit spends `blank` dark cycles then SHOW cycles, one cycle late.
    function automatic logic [3:0] exp_sel(int k, int p, int blank, logic [3:0] lit);
        int d   = (k - 1) / p;
        int pos = (k - 1) % p;
        if (pos < blank || !lit[d]) return 4'hF;
        return ~(4'b0001 << d);
    endfunction

    function automatic logic [7:0] exp_seg(int k, int p, int blank, logic [3:0] lit, logic [31:0] segs);
        int d   = (k - 1) / p;
        int pos = (k - 1) % p;
        if (pos < blank || !lit[d]) return 8'hFF;
        return segs[8*d +: 8];
    endfunction

    // Records `len` cycles after the current negedge; optionally pulses load at cycle load_at.
    task automatic capture(input int len, input int load_at, input logic [15:0] ld_data,
                           input logic [3:0] ld_dp);
        if (load_at == 0) begin
            data_in = ld_data;
            dp_in   = ld_dp;
            load    = 1'b1;
        end
        for (int k = 1; k <= len; k++) begin
            @(negedge clk);
            load       = 1'b0;
            cap_sel[k] = mon_sel;
            cap_seg[k] = mon_seg;
            cap_fd[k]  = mon_fd;
            if (k == load_at) begin
                data_in = ld_data;
                dp_in   = ld_dp;
                load    = 1'b1;
            end
        end
    endtask

    task automatic wait_fd(input string name);
        bit seen = 0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(negedge clk);
            if (mon_fd === 1'b1) seen = 1;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("FAIL %s_frame_done_timeout got none within 100 cycles, required a pulse", name);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (if_a.sel !== 4'hF || if_a.seg !== 8'hFF || if_a.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_a sel=%h seg=%h fd=%b required sel=f seg=ff fd=0",
                     if_a.sel, if_a.seg, if_a.frame_done);
        end
        checks++;
        if (if_lz.sel !== 4'hF || if_lz.seg !== 8'hFF || if_lz.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_lz sel=%h seg=%h fd=%b required sel=f seg=ff fd=0",
                     if_lz.sel, if_lz.seg, if_lz.frame_done);
        end
        checks++;
        if (if_nb.sel !== 4'hF || if_nb.seg !== 8'hFF || if_nb.frame_done !== 1'b0) begin
            failures++;
            $display("FAIL reset_nb sel=%h seg=%h fd=%b required sel=f seg=ff fd=0",
                     if_nb.sel, if_nb.seg, if_nb.frame_done);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic_scan();
        mon = 0;
        capture(24, 0, 16'h12AF, 4'b0000);
        for (int k = 1; k <= 24; k++) begin
            checks++;
            if (cap_sel[k] !== exp_sel(k, 6, 2, 4'hF) || cap_seg[k] !== exp_seg(k, 6, 2, 4'hF, {4{8'h03}})
                || cap_fd[k] !== logic'(k == 24)) begin
                failures++;
                $display("FAIL basic_first_frame k=%0d sel=%h seg=%h fd=%b required sel=%h seg=%h fd=%b",
                         k, cap_sel[k], cap_seg[k], cap_fd[k], exp_sel(k, 6, 2, 4'hF),
                         exp_seg(k, 6, 2, 4'hF, {4{8'h03}}), k == 24);
            end
        end
        capture(24, -1, 16'h0, 4'h0);
        for (int k = 1; k <= 24; k++) begin
            checks++;
            if (cap_sel[k] !== exp_sel(k, 6, 2, 4'hF) || cap_seg[k] !== exp_seg(k, 6, 2, 4'hF, 32'h7111259F)
                || cap_fd[k] !== logic'(k == 24)) begin
                failures++;
                $display("FAIL basic_12AF k=%0d sel=%h seg=%h fd=%b required sel=%h seg=%h fd=%b",
                         k, cap_sel[k], cap_seg[k], cap_fd[k], exp_sel(k, 6, 2, 4'hF),
                         exp_seg(k, 6, 2, 4'hF, 32'h7111259F), k == 24);
            end
        end
    endtask

    task automatic test_frame_coherent();
        capture(24, 3, 16'h1111, 4'b0000);
        capture(24, 10, 16'h2222, 4'b0000);
        for (int k = 1; k <= 24; k++) begin
            checks++;
            if (cap_sel[k] !== exp_sel(k, 6, 2, 4'hF) || cap_seg[k] !== exp_seg(k, 6, 2, 4'hF, {4{8'h9F}})) begin
                failures++;
                $display("FAIL coherent_1111 k=%0d sel=%h seg=%h required sel=%h seg=%h",
                         k, cap_sel[k], cap_seg[k], exp_sel(k, 6, 2, 4'hF), exp_seg(k, 6, 2, 4'hF, {4{8'h9F}}));
            end
        end
        capture(24, 23, 16'h3333, 4'b0000);
        for (int k = 1; k <= 24; k++) begin
            checks++;
            if (cap_sel[k] !== exp_sel(k, 6, 2, 4'hF) || cap_seg[k] !== exp_seg(k, 6, 2, 4'hF, {4{8'h25}})) begin
                failures++;
                $display("FAIL coherent_2222 k=%0d sel=%h seg=%h required sel=%h seg=%h",
                         k, cap_sel[k], cap_seg[k], exp_sel(k, 6, 2, 4'hF), exp_seg(k, 6, 2, 4'hF, {4{8'h25}}));
            end
        end
        capture(24, -1, 16'h0, 4'h0);
        for (int k = 1; k <= 24; k++) begin
            checks++;
            if (cap_sel[k] !== exp_sel(k, 6, 2, 4'hF) || cap_seg[k] !== exp_seg(k, 6, 2, 4'hF, {4{8'h0D}})) begin
                failures++;
                $display("FAIL coherent_boundary_load k=%0d sel=%h seg=%h required sel=%h seg=%h",
                         k, cap_sel[k], cap_seg[k], exp_sel(k, 6, 2, 4'hF), exp_seg(k, 6, 2, 4'hF, {4{8'h0D}}));
            end
        end
    endtask

    task automatic test_dp();
        capture(24, 0, 16'h0000, 4'b0010);
        capture(24, -1, 16'h0, 4'h0);
        for (int k = 1; k <= 24; k++) begin
            checks++;
            if (cap_sel[k] !== exp_sel(k, 6, 2, 4'hF) || cap_seg[k] !== exp_seg(k, 6, 2, 4'hF, 32'h03030203)) begin
                failures++;
                $display("FAIL dp_digit1 k=%0d sel=%h seg=%h required sel=%h seg=%h",
                         k, cap_sel[k], cap_seg[k], exp_sel(k, 6, 2, 4'hF), exp_seg(k, 6, 2, 4'hF, 32'h03030203));
            end
        end
    endtask

    task automatic test_lz_blank();
        mon = 1;
        wait_fd("lz");
        capture(24, 0, 16'h0050, 4'b0000);
        capture(24, 0, 16'h0000, 4'b0000);
        for (int k = 1; k <= 24; k++) begin
            checks++;
            if (cap_sel[k] !== exp_sel(k, 6, 2, 4'b1100) || cap_seg[k] !== exp_seg(k, 6, 2, 4'b1100, 32'h0349FFFF)) begin
                failures++;
                $display("FAIL lz_0050 k=%0d sel=%h seg=%h required sel=%h seg=%h",
                         k, cap_sel[k], cap_seg[k], exp_sel(k, 6, 2, 4'b1100), exp_seg(k, 6, 2, 4'b1100, 32'h0349FFFF));
            end
        end
        capture(24, 0, 16'h0000, 4'b0001);
        for (int k = 1; k <= 24; k++) begin
            checks++;
            if (cap_sel[k] !== exp_sel(k, 6, 2, 4'b1000) || cap_seg[k] !== exp_seg(k, 6, 2, 4'b1000, 32'h03FFFFFF)) begin
                failures++;
                $display("FAIL lz_0000 k=%0d sel=%h seg=%h required sel=%h seg=%h",
                         k, cap_sel[k], cap_seg[k], exp_sel(k, 6, 2, 4'b1000), exp_seg(k, 6, 2, 4'b1000, 32'h03FFFFFF));
            end
        end
        capture(24, -1, 16'h0, 4'h0);
        for (int k = 1; k <= 24; k++) begin
            checks++;
            if (cap_sel[k] !== exp_sel(k, 6, 2, 4'hF) || cap_seg[k] !== exp_seg(k, 6, 2, 4'hF, 32'h03030302)) begin
                failures++;
                $display("FAIL lz_dp0 k=%0d sel=%h seg=%h required sel=%h seg=%h",
                         k, cap_sel[k], cap_seg[k], exp_sel(k, 6, 2, 4'hF), exp_seg(k, 6, 2, 4'hF, 32'h03030302));
            end
        end
    endtask

    task automatic test_enable();
        mon = 0;
        wait_fd("enable");
        enable_n = 1'b1;
        capture(24, -1, 16'h0, 4'h0);
        enable_n = 1'b0;
        for (int k = 1; k <= 24; k++) begin
            checks++;
            if (cap_sel[k] !== 4'hF || cap_seg[k] !== 8'hFF || cap_fd[k] !== logic'(k == 24)) begin
                failures++;
                $display("FAIL enable_dark k=%0d sel=%h seg=%h fd=%b required sel=f seg=ff fd=%b",
                         k, cap_sel[k], cap_seg[k], cap_fd[k], k == 24);
            end
        end
        capture(24, -1, 16'h0, 4'h0);
        for (int k = 1; k <= 24; k++) begin
            checks++;
            if (cap_sel[k] !== exp_sel(k, 6, 2, 4'hF) || cap_seg[k] !== exp_seg(k, 6, 2, 4'hF, 32'h03030302)) begin
                failures++;
                $display("FAIL enable_resume k=%0d sel=%h seg=%h required sel=%h seg=%h",
                         k, cap_sel[k], cap_seg[k], exp_sel(k, 6, 2, 4'hF), exp_seg(k, 6, 2, 4'hF, 32'h03030302));
            end
        end
    endtask

    task automatic test_no_blank();
        mon = 2;
        wait_fd("no_blank");
        capture(16, -1, 16'h0, 4'h0);
        for (int k = 1; k <= 16; k++) begin
            checks++;
            if (cap_sel[k] !== exp_sel(k, 4, 0, 4'hF) || cap_seg[k] !== exp_seg(k, 4, 0, 4'hF, 32'h03030302)
                || cap_fd[k] !== logic'(k == 16)) begin
                failures++;
                $display("FAIL no_blank k=%0d sel=%h seg=%h fd=%b required sel=%h seg=%h fd=%b",
                         k, cap_sel[k], cap_seg[k], cap_fd[k], exp_sel(k, 4, 0, 4'hF),
                         exp_seg(k, 4, 0, 4'hF, 32'h03030302), k == 16);
            end
        end
    endtask

    task automatic test_reset_mid_scan();
        mon = 0;
        wait_fd("mid_reset");
        for (int k = 1; k <= 15; k++) begin
            @(negedge clk);
            load = 1'b0;
            if (k == 3) begin
                data_in = 16'h9999;
                dp_in   = 4'b1111;
                load    = 1'b1;
            end
        end
        checks++;
        if (mon_sel !== 4'b1011) begin
            failures++;
            $display("FAIL mid_reset_digit2_lit sel=%h required sel=b", mon_sel);
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (mon_sel !== 4'hF || mon_seg !== 8'hFF || mon_fd !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_outputs sel=%h seg=%h fd=%b required sel=f seg=ff fd=0",
                     mon_sel, mon_seg, mon_fd);
        end
        rst = 1'b0;
        for (int f = 0; f < 2; f++) begin
            capture(24, -1, 16'h0, 4'h0);
            for (int k = 1; k <= 24; k++) begin
                checks++;
                if (cap_sel[k] !== exp_sel(k, 6, 2, 4'hF) || cap_seg[k] !== exp_seg(k, 6, 2, 4'hF, {4{8'h03}})
                    || cap_fd[k] !== logic'(k == 24)) begin
                    failures++;
                    $display("FAIL mid_reset_frame%0d k=%0d sel=%h seg=%h fd=%b required sel=%h seg=%h fd=%b",
                             f, k, cap_sel[k], cap_seg[k], cap_fd[k], exp_sel(k, 6, 2, 4'hF),
                             exp_seg(k, 6, 2, 4'hF, {4{8'h03}}), k == 24);
                end
                checks++;
                if ($countones(~cap_sel[k]) > 1) begin
                    failures++;
                    $display("FAIL sel_onehot k=%0d sel=%h required one-hot-low or all high", k, cap_sel[k]);
                end
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        mon      = 0;
        rst      = 1'b1;
        data_in  = 16'h0;
        dp_in    = 4'h0;
        load     = 1'b0;
        enable_n = 1'b0;
        test_reset();
        test_basic_scan();
        test_frame_coherent();
        test_dp();
        test_lz_blank();
        test_enable();
        test_no_blank();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
